// File: rtl/mem_arbiter.sv
// Arbitrates a single memory request/response port between the IFU and the LSU.
// Optional ARB_RR_EN: round-robin tie-break instead of fixed LSU priority.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ifu_req_valid_i,
    output logic                ifu_req_ready_o,
    input  logic [ADDR_W-1:0]   ifu_addr_i,
    output logic                ifu_resp_valid_o,
    input  logic                ifu_resp_ready_i,
    output logic [DATA_W-1:0]   ifu_rdata_o,
    input  logic                lsu_req_valid_i,
    output logic                lsu_req_ready_o,
    input  logic [ADDR_W-1:0]   lsu_addr_i,
    input  logic                lsu_wen_i,
    input  logic [DATA_W-1:0]   lsu_wdata_i,
    input  logic [DATA_W/8-1:0] lsu_wstrb_i,
    output logic                lsu_resp_valid_o,
    input  logic                lsu_resp_ready_i,
    output logic [DATA_W-1:0]   lsu_rdata_o,
    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic                mem_wen_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_wstrb_o,
    input  logic                mem_resp_valid_i,
    output logic                mem_resp_ready_o,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_IFU_REQ,
        S_IFU_RESP,
        S_LSU_REQ,
        S_LSU_RESP
    } state_t;

    state_t state_q, state_d;
    logic   pick_lsu;

    assign ifu_rdata_o = mem_rdata_i;
    assign lsu_rdata_o = mem_rdata_i;

`ifdef ARB_RR_EN
    // 1 = LSU owned the last completed transaction; reset value makes the first tie go to the IFU.
    logic last_lsu_q, last_lsu_d;

    assign pick_lsu = lsu_req_valid_i && !(ifu_req_valid_i && last_lsu_q);

    always_ff @(posedge clock) begin
        if (reset) last_lsu_q <= 1'b1;
        else       last_lsu_q <= last_lsu_d;
    end
`else
    assign pick_lsu = lsu_req_valid_i;
`endif

    always_ff @(posedge clock) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d          = state_q;
        ifu_req_ready_o  = 1'b0;
        ifu_resp_valid_o = 1'b0;
        lsu_req_ready_o  = 1'b0;
        lsu_resp_valid_o = 1'b0;
        mem_req_valid_o  = 1'b0;
        mem_resp_ready_o = 1'b0;
        mem_addr_o       = '0;
        mem_wen_o        = 1'b0;
        mem_wdata_o      = '0;
        mem_wstrb_o      = '0;
`ifdef ARB_RR_EN
        last_lsu_d       = last_lsu_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (ifu_req_valid_i || lsu_req_valid_i)
                    state_d = pick_lsu ? S_LSU_REQ : S_IFU_REQ;
            end
            S_IFU_REQ: begin
                mem_req_valid_o = ifu_req_valid_i;
                ifu_req_ready_o = mem_req_ready_i;
                mem_addr_o      = ifu_addr_i;
                if (ifu_req_valid_i && mem_req_ready_i) state_d = S_IFU_RESP;
            end
            S_IFU_RESP: begin
                ifu_resp_valid_o = mem_resp_valid_i;
                mem_resp_ready_o = ifu_resp_ready_i;
                if (mem_resp_valid_i && ifu_resp_ready_i) begin
                    state_d = S_IDLE;
`ifdef ARB_RR_EN
                    last_lsu_d = 1'b0;
`endif
                end
            end
            S_LSU_REQ: begin
                mem_req_valid_o = lsu_req_valid_i;
                lsu_req_ready_o = mem_req_ready_i;
                mem_addr_o      = lsu_addr_i;
                mem_wen_o       = lsu_wen_i;
                mem_wdata_o     = lsu_wdata_i;
                mem_wstrb_o     = lsu_wstrb_i;
                if (lsu_req_valid_i && mem_req_ready_i) state_d = S_LSU_RESP;
            end
            S_LSU_RESP: begin
                lsu_resp_valid_o = mem_resp_valid_i;
                mem_resp_ready_o = lsu_resp_ready_i;
                if (mem_resp_valid_i && lsu_resp_ready_i) begin
                    state_d = S_IDLE;
`ifdef ARB_RR_EN
                    last_lsu_d = 1'b1;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus tie, starvation and reset sequences.
module tb_mem_arbiter;

    localparam logic [31:0] IFU_A = 32'h8000_0000;
    localparam logic [31:0] LSU_A = 32'h8000_0010;
    localparam logic [31:0] WDATA = 32'h1234_5678;
    localparam logic [3:0]  WSTRB = 4'b0011;
    localparam int P_NONE = 0, P_IFU = 1, P_LSU = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        ifu_req_valid_i, ifu_req_ready_o, ifu_resp_valid_o, ifu_resp_ready_i;
    logic [31:0] ifu_addr_i, ifu_rdata_o;
    logic        lsu_req_valid_i, lsu_req_ready_o, lsu_wen_i, lsu_resp_valid_o, lsu_resp_ready_i;
    logic [31:0] lsu_addr_i, lsu_wdata_i, lsu_rdata_o;
    logic [3:0]  lsu_wstrb_i;
    logic        mem_req_valid_o, mem_req_ready_i, mem_wen_o, mem_resp_valid_i, mem_resp_ready_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [3:0]  mem_wstrb_o;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clock(clock), .reset(reset),
        .ifu_req_valid_i(ifu_req_valid_i), .ifu_req_ready_o(ifu_req_ready_o),
        .ifu_addr_i(ifu_addr_i), .ifu_resp_valid_o(ifu_resp_valid_o),
        .ifu_resp_ready_i(ifu_resp_ready_i), .ifu_rdata_o(ifu_rdata_o),
        .lsu_req_valid_i(lsu_req_valid_i), .lsu_req_ready_o(lsu_req_ready_o),
        .lsu_addr_i(lsu_addr_i), .lsu_wen_i(lsu_wen_i), .lsu_wdata_i(lsu_wdata_i),
        .lsu_wstrb_i(lsu_wstrb_i), .lsu_resp_valid_o(lsu_resp_valid_o),
        .lsu_resp_ready_i(lsu_resp_ready_i), .lsu_rdata_o(lsu_rdata_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_addr_o(mem_addr_o), .mem_wen_o(mem_wen_o), .mem_wdata_o(mem_wdata_o),
        .mem_wstrb_o(mem_wstrb_o), .mem_resp_valid_i(mem_resp_valid_i),
        .mem_resp_ready_o(mem_resp_ready_o), .mem_rdata_i(mem_rdata_i)
    );

    // {ifu_rdy, ifu_rv, lsu_rdy, lsu_rv, mreq_v, mresp_rdy, wen, addr, wdata, wstrb, ifu_rdata, lsu_rdata}
    logic [138:0] act;
    assign act = {ifu_req_ready_o, ifu_resp_valid_o, lsu_req_ready_o, lsu_resp_valid_o,
                  mem_req_valid_o, mem_resp_ready_o, mem_wen_o, mem_addr_o, mem_wdata_o,
                  mem_wstrb_o, ifu_rdata_o, lsu_rdata_o};

    typedef struct {
        logic        ifu_v, ifu_rr, lsu_v, lsu_wen, lsu_rr, mreq_rdy, mresp_v;
        logic [31:0] rdata;
        logic [5:0]  hs;
        int          psel;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic iv, logic irr, logic lv, logic lw, logic lrr,
                                logic mrdy, logic mrv, logic [31:0] rd, logic [5:0] hs, int ps);
        vec_t v;
        v.ifu_v = iv; v.ifu_rr = irr; v.lsu_v = lv; v.lsu_wen = lw; v.lsu_rr = lrr;
        v.mreq_rdy = mrdy; v.mresp_v = mrv; v.rdata = rd; v.hs = hs; v.psel = ps;
        return v;
    endfunction

    // Expected payload: zero outside REQ, IFU payload is a read with no data/strobes.
    function automatic logic [138:0] expv(logic [5:0] hs, int ps, logic wen, logic [31:0] rd);
        logic [31:0] a, wd;
        logic [3:0]  ws;
        logic        w;
        a = '0; wd = '0; ws = '0; w = 1'b0;
        if (ps == P_IFU) a = IFU_A;
        if (ps == P_LSU) begin a = LSU_A; wd = WDATA; ws = WSTRB; w = wen; end
        return {hs, w, a, wd, ws, rd, rd};
    endfunction

    task automatic drive(logic iv, logic irr, logic lv, logic lw, logic lrr,
                         logic mrdy, logic mrv, logic [31:0] rd);
        ifu_req_valid_i = iv; ifu_resp_ready_i = irr;
        lsu_req_valid_i = lv; lsu_wen_i = lw; lsu_resp_ready_i = lrr;
        mem_req_ready_i = mrdy; mem_resp_valid_i = mrv; mem_rdata_i = rd;
    endtask

    task automatic check(string name, logic [138:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] lsu_on, own_lsu;
        ifu_addr_i = IFU_A; lsu_addr_i = LSU_A; lsu_wdata_i = WDATA; lsu_wstrb_i = WSTRB;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, '0);

        // Test 1: lone IFU read
        vecs.push_back(mk(1,0,0,0,0,0,0, 32'h0,        6'b000000, P_NONE));
        vecs.push_back(mk(1,0,0,0,0,1,0, 32'h0,        6'b100010, P_IFU));
        vecs.push_back(mk(0,1,0,0,0,0,1, 32'hDEADBEEF, 6'b010001, P_NONE));
        vecs.push_back(mk(0,0,0,0,0,0,0, 32'h0,        6'b000000, P_NONE));
        // Test 4: LSU write, memory stalls 4 cycles
        vecs.push_back(mk(0,0,1,1,0,0,0, 32'h0,        6'b000000, P_NONE));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0,0,1,1,0,0,0, 32'h0,    6'b000010, P_LSU));
        vecs.push_back(mk(0,0,1,1,0,1,0, 32'h0,        6'b001010, P_LSU));
        // Test 5: owner holds resp_ready low; pending IFU must not be granted
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1,0,0,0,0,0,1, 32'h11110000, 6'b000100, P_NONE));
        vecs.push_back(mk(1,0,0,0,1,0,1, 32'h0,        6'b000101, P_NONE));
        // Response in IDLE is not acknowledged
        vecs.push_back(mk(0,0,0,0,0,0,1, 32'h00000055, 6'b000000, P_NONE));
        // LSU read; early response in LSU_REQ not acknowledged
        vecs.push_back(mk(0,0,1,0,0,0,0, 32'h0,        6'b000000, P_NONE));
        vecs.push_back(mk(0,0,1,0,0,0,1, 32'h00000077, 6'b000010, P_LSU));
        vecs.push_back(mk(0,0,1,0,0,1,0, 32'h0,        6'b001010, P_LSU));
        vecs.push_back(mk(0,0,0,0,1,0,1, 32'hCAFEF00D, 6'b000101, P_NONE));
        vecs.push_back(mk(0,0,0,0,0,0,0, 32'h0,        6'b000000, P_NONE));
        // IFU drops valid in IFU_REQ: arbiter holds the grant
        vecs.push_back(mk(1,0,0,0,0,0,0, 32'h0,        6'b000000, P_NONE));
        vecs.push_back(mk(0,0,0,0,0,0,0, 32'h0,        6'b000000, P_IFU));
        vecs.push_back(mk(1,0,0,0,0,1,0, 32'h0,        6'b100010, P_IFU));
        vecs.push_back(mk(0,1,0,0,0,0,1, 32'hA5A5A5A5, 6'b010001, P_NONE));

        repeat (2) @(negedge clock);
        #1 check("reset_state", expv(6'b0, P_NONE, 1'b0, '0));
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].ifu_v, vecs[i].ifu_rr, vecs[i].lsu_v, vecs[i].lsu_wen, vecs[i].lsu_rr,
                  vecs[i].mreq_rdy, vecs[i].mresp_v, vecs[i].rdata);
            #1 check($sformatf("vec%0d", i),
                     expv(vecs[i].hs, vecs[i].psel, vecs[i].lsu_wen, vecs[i].rdata));
            @(negedge clock);
        end

        // Ties: fresh reset so the round-robin history starts from LSU
        drive(0, 0, 0, 0, 0, 0, 0, '0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
`ifdef ARB_RR_EN
        lsu_on = 3'b111; own_lsu = 3'b010;
`else
        lsu_on = 3'b011; own_lsu = 3'b011;
`endif
        for (int t = 0; t < 3; t++) begin
            drive(1, 0, lsu_on[t], 0, 0, 0, 0, '0);
            #1 check($sformatf("tie%0d_idle", t), expv(6'b0, P_NONE, 1'b0, '0));
            @(negedge clock);
            drive(1, 0, lsu_on[t], 0, 0, 1, 0, '0);
            #1 check($sformatf("tie%0d_grant", t),
                     own_lsu[t] ? expv(6'b001010, P_LSU, 1'b0, '0) : expv(6'b100010, P_IFU, 1'b0, '0));
            @(negedge clock);
            drive(!own_lsu[t], 1, own_lsu[t] ? 1'b0 : lsu_on[t], 0, 1, 0, 1, 32'h600D0000 + t);
            #1 check($sformatf("tie%0d_resp", t),
                     expv(own_lsu[t] ? 6'b000101 : 6'b010001, P_NONE, 1'b0, 32'h600D0000 + t));
            @(negedge clock);
        end

        // Test 6: reset while in LSU_RESP
        drive(0, 0, 1, 0, 0, 0, 0, '0);
        @(negedge clock);
        drive(0, 0, 1, 0, 0, 1, 0, '0);
        #1 check("rst_lsu_grant", expv(6'b001010, P_LSU, 1'b0, '0));
        @(negedge clock);
        drive(0, 0, 0, 0, 0, 0, 1, 32'h12121212);
        #1 check("rst_lsu_resp", expv(6'b000100, P_NONE, 1'b0, 32'h12121212));
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        drive(1, 1, 1, 1, 1, 1, 1, 32'h0BADF00D);
        #1 check("rst_to_idle", expv(6'b0, P_NONE, 1'b0, 32'h0BADF00D));
        @(negedge clock);
        drive(0, 0, 0, 0, 0, 0, 0, '0);
        repeat (2) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
